micro_ondas_ctrl: RTL and testbench

//   Cooking sequencer for the microwave. Collects keypad digits into an M:SS

---
 rtl/micro_ondas_ctrl.sv | 163 ++++++++++++++++
 tb/tb_micro_ondas_ctrl.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/micro_ondas_ctrl.sv
// micro_ondas_ctrl: microwave cooking sequencer. Builds an M:SS entry from
// keypad digits, drives the countdown timer and gates the magnetron.
// Ports:
//   clock, resetn                   clock and async active-low reset
//   keypad[9:0]                     one-hot digit keys
//   startn, stopn, clearn           active-low buttons
//   door_closed, timer_zero         door switch, timer at 0:00
//   timer_load, timer_data[11:0]    load pulse and BCD entry
//   timer_dec, timer_clear          1 s decrement pulse, clear pulse
//   mag_on, done                    magnetron enable, finished indicator
module micro_ondas_ctrl #(
  parameter int TICKS_PER_SEC = 100,
  parameter int DONE_HOLD     = 3
) (
  input  logic        clock,
  input  logic        resetn,
  input  logic [9:0]  keypad,
  input  logic        startn,
  input  logic        stopn,
  input  logic        clearn,
  input  logic        door_closed,
  input  logic        timer_zero,
  output logic        timer_load,
  output logic [11:0] timer_data,
  output logic        timer_dec,
  output logic        timer_clear,
  output logic        mag_on,
  output logic        done
);

  localparam int HOLD = DONE_HOLD * TICKS_PER_SEC;
  localparam int PW = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
  localparam int DW = (HOLD > 1) ? $clog2(HOLD) : 1;
  localparam logic [PW-1:0] P_MAX = PW'(TICKS_PER_SEC - 1);
  localparam logic [DW-1:0] D_MAX = DW'(HOLD - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    COOK  = 2'd1,
    PAUSE = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t        state, state_n;
  logic [11:0]   entry_n;
  logic [PW-1:0] presc, presc_n;
  logic [DW-1:0] dcnt, dcnt_n;
  logic          start_q, stop_q, clear_q;
  logic [9:0]    key_q;
  logic          load_n, dec_n, clr_n;

  logic       start_ev, stop_ev, clr_ev, key_ev, any_ev;
  logic [3:0] digit;

  assign start_ev = start_q & ~startn;
  assign stop_ev  = stop_q & ~stopn;
  assign clr_ev   = clear_q & ~clearn;
  // A key counts only when the pad was released before and exactly one
  // line is now active; chords and held keys do nothing.
  assign key_ev   = (key_q == '0) && $onehot(keypad);
  assign any_ev   = start_ev | stop_ev | clr_ev | key_ev;

  always_comb begin
    digit = '0;
    for (int k = 0; k < 10; k++) begin
      if (keypad[k]) digit = 4'(k);
    end
  end

  always_comb begin
    state_n = state;
    entry_n = timer_data;
    presc_n = presc;
    dcnt_n  = dcnt;
    load_n  = 1'b0;
    dec_n   = 1'b0;
    clr_n   = 1'b0;
    case (state)
      IDLE: begin
        if (clr_ev) begin
          entry_n = '0;
          clr_n   = 1'b1;
        end else if (start_ev && door_closed
                     && timer_data != '0) begin
          state_n = COOK;
          presc_n = '0;
        end else if (key_ev) begin
          entry_n = {timer_data[7:0], digit};
          load_n  = 1'b1;
        end
      end
      COOK: begin
        if (clr_ev) begin
          state_n = IDLE;
          entry_n = '0;
          clr_n   = 1'b1;
        end else if (timer_zero) begin
          state_n = DONE;
          dcnt_n  = '0;
        end else if (!door_closed || stop_ev) begin
          state_n = PAUSE;
        end else if (presc == P_MAX) begin
          presc_n = '0;
          dec_n   = 1'b1;
        end else begin
          presc_n = presc + 1'b1;
        end
      end
      PAUSE: begin
        if (clr_ev || stop_ev) begin
          state_n = IDLE;
          entry_n = '0;
          clr_n   = 1'b1;
        end else if (start_ev && door_closed) begin
          state_n = COOK;
        end
      end
      DONE: begin
        if (any_ev || dcnt == D_MAX) begin
          state_n = IDLE;
          entry_n = '0;
          clr_n   = 1'b1;
        end else begin
          dcnt_n = dcnt + 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state       <= IDLE;
      timer_data  <= '0;
      presc       <= '0;
      dcnt        <= '0;
      start_q     <= 1'b1;
      stop_q      <= 1'b1;
      clear_q     <= 1'b1;
      key_q       <= '0;
      timer_load  <= 1'b0;
      timer_dec   <= 1'b0;
      timer_clear <= 1'b0;
      mag_on      <= 1'b0;
      done        <= 1'b0;
    end else begin
      state       <= state_n;
      timer_data  <= entry_n;
      presc       <= presc_n;
      dcnt        <= dcnt_n;
      start_q     <= startn;
      stop_q      <= stopn;
      clear_q     <= clearn;
      key_q       <= keypad;
      timer_load  <= load_n;
      timer_dec   <= dec_n;
      timer_clear <= clr_n;
      mag_on      <= (state_n == COOK);
      done        <= (state_n == DONE);
    end
  end

endmodule

// File: tb/tb_micro_ondas_ctrl.sv
// tb_micro_ondas_ctrl: directed bench for the microwave sequencer,
// run with TICKS_PER_SEC=4 and DONE_HOLD=2.
module tb_micro_ondas_ctrl;

  logic        clock = 1'b0;
  logic        run = 1'b1;
  logic        resetn;
  logic [9:0]  keypad;
  logic        startn, stopn, clearn;
  logic        door_closed, timer_zero;
  logic        timer_load, timer_dec, timer_clear;
  logic        mag_on, done;
  logic [11:0] timer_data;

  int checks = 0;
  int failures = 0;

  micro_ondas_ctrl #(.TICKS_PER_SEC(4), .DONE_HOLD(2)) dut (
    .clock(clock), .resetn(resetn), .keypad(keypad),
    .startn(startn), .stopn(stopn), .clearn(clearn),
    .door_closed(door_closed), .timer_zero(timer_zero),
    .timer_load(timer_load), .timer_data(timer_data),
    .timer_dec(timer_dec), .timer_clear(timer_clear),
    .mag_on(mag_on), .done(done)
  );

  always begin
    #5;
    if (run) clock = ~clock;
  end

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic key(input int d, input logic [11:0] exp);
    keypad = 10'(1 << d);
    step();
    chk("key_load", timer_load, 1);
    chk("key_data", timer_data, exp);
    keypad = '0;
    step();
    chk("key_load_end", timer_load, 0);
  endtask

  task automatic outs_zero(input string tag);
    chk({tag, "_load"}, timer_load, 0);
    chk({tag, "_data"}, timer_data, 0);
    chk({tag, "_dec"}, timer_dec, 0);
    chk({tag, "_clr"}, timer_clear, 0);
    chk({tag, "_mag"}, mag_on, 0);
    chk({tag, "_done"}, done, 0);
  endtask

  initial begin
    resetn = 1'b0;
    keypad = '0;
    startn = 1'b1;
    stopn = 1'b1;
    clearn = 1'b1;
    door_closed = 1'b1;
    timer_zero = 1'b0;
    step();
    step();
    outs_zero("reset");
    resetn = 1'b1;
    step();

    // keypad entry
    key(2, 12'h002);
    key(1, 12'h021);
    key(1, 12'h211);
    key(2, 12'h112);
    key(3, 12'h123);
    keypad = 10'(1 << 4);
    step();
    chk("k4_load", timer_load, 1);
    chk("k4_data", timer_data, 12'h234);
    step();
    chk("held_load", timer_load, 0);
    chk("held_data", timer_data, 12'h234);
    keypad = '0;
    step();
    keypad = 10'b0000000011;
    step();
    chk("multi_load", timer_load, 0);
    chk("multi_data", timer_data, 12'h234);
    keypad = '0;
    step();
    clearn = 1'b0;
    step();
    chk("clr_pulse", timer_clear, 1);
    chk("clr_data", timer_data, 0);
    clearn = 1'b1;
    step();
    chk("clr_end", timer_clear, 0);

    // cooking and decrement cadence
    key(2, 12'h002);
    key(1, 12'h021);
    startn = 1'b0;
    step();
    chk("cook_mag", mag_on, 1);
    startn = 1'b1;
    keypad = 10'b0000000011;
    for (int i = 1; i <= 10; i++) begin
      step();
      chk($sformatf("dec_%0d", i), timer_dec, (i % 4 == 0) ? 1 : 0);
      chk($sformatf("cook_load_%0d", i), timer_load, 0);
    end
    keypad = '0;
    chk("cook_data", timer_data, 12'h021);

    // door open pauses, closing alone does not resume
    door_closed = 1'b0;
    step();
    chk("pause_mag", mag_on, 0);
    for (int i = 0; i < 5; i++) begin
      step();
      chk($sformatf("pause_dec_%0d", i), timer_dec, 0);
    end
    door_closed = 1'b1;
    step();
    step();
    chk("closed_mag", mag_on, 0);
    startn = 1'b0;
    step();
    chk("resume_mag", mag_on, 1);
    chk("resume_dec0", timer_dec, 0);
    startn = 1'b1;
    step();
    chk("resume_dec1", timer_dec, 0);
    step();
    chk("resume_dec2", timer_dec, 1);

    // timer reaches zero, done hold
    timer_zero = 1'b1;
    step();
    chk("done_mag", mag_on, 0);
    chk("done_on", done, 1);
    timer_zero = 1'b0;
    for (int j = 1; j <= 7; j++) begin
      step();
      chk($sformatf("done_hold_%0d", j), done, 1);
      chk($sformatf("done_clr_%0d", j), timer_clear, 0);
    end
    step();
    chk("done_exit", done, 0);
    chk("done_exit_clr", timer_clear, 1);
    chk("done_exit_data", timer_data, 0);
    step();
    chk("done_clr_end", timer_clear, 0);

    // key during done exits at once and is consumed
    key(2, 12'h002);
    key(1, 12'h021);
    startn = 1'b0;
    step();
    startn = 1'b1;
    timer_zero = 1'b1;
    step();
    timer_zero = 1'b0;
    step();
    step();
    chk("done2_on", done, 1);
    keypad = 10'(1 << 5);
    step();
    chk("dkey_done", done, 0);
    chk("dkey_clr", timer_clear, 1);
    chk("dkey_load", timer_load, 0);
    chk("dkey_data", timer_data, 0);
    keypad = '0;
    step();
    chk("dkey_clr_end", timer_clear, 0);

    // start rejected with zero entry or open door
    startn = 1'b0;
    step();
    chk("zero_start", mag_on, 0);
    startn = 1'b1;
    step();
    key(2, 12'h002);
    key(1, 12'h021);
    door_closed = 1'b0;
    startn = 1'b0;
    step();
    chk("open_start", mag_on, 0);
    startn = 1'b1;
    step();
    door_closed = 1'b1;
    clearn = 1'b0;
    startn = 1'b0;
    step();
    chk("both_clr", timer_clear, 1);
    chk("both_mag", mag_on, 0);
    chk("both_data", timer_data, 0);
    clearn = 1'b1;
    startn = 1'b1;
    step();
    chk("both_mag2", mag_on, 0);

    // stop in pause returns to idle with a clear
    key(3, 12'h003);
    startn = 1'b0;
    step();
    startn = 1'b1;
    chk("stop_cook", mag_on, 1);
    stopn = 1'b0;
    step();
    chk("stop_pause", mag_on, 0);
    chk("stop_pause_clr", timer_clear, 0);
    stopn = 1'b1;
    step();
    stopn = 1'b0;
    step();
    chk("stop_idle_clr", timer_clear, 1);
    chk("stop_idle_data", timer_data, 0);
    stopn = 1'b1;
    step();

    // asynchronous reset with the clock stopped
    key(2, 12'h002);
    startn = 1'b0;
    step();
    startn = 1'b1;
    chk("ar_cook", mag_on, 1);
    run = 1'b0;
    #3;
    resetn = 1'b0;
    #1;
    chk("ar_mag", mag_on, 0);
    #10;
    resetn = 1'b1;
    #2;
    run = 1'b1;
    step();
    outs_zero("post_reset");
    startn = 1'b0;
    step();
    chk("post_start", mag_on, 0);
    startn = 1'b1;
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
